// File: rtl/window_deser_pkg.sv
// window_deser_pkg: shared state type, default sizes and slot mapping for the window deserialiser
package window_deser_pkg;

    typedef enum logic {ST_FILL, ST_STALL} state_t;

    localparam int DESER_DATA_W = 8;
    localparam int DESER_N      = 5;
    localparam int COL_W        = DESER_N * DESER_DATA_W;
    localparam int WIN_W        = DESER_N * DESER_N * DESER_DATA_W;
    localparam int CNT_W        = $clog2(DESER_N + 1);

    // pixel at column c, row r lands in row-major slot r*n+c (0-based)
    function automatic int col_row_to_slot(input int c, input int r, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/column_shift_bank.sv
// column_shift_bank: N-column shift register, oldest column at index 0, exposed as a row-major window
module column_shift_bank
    import window_deser_pkg::*;
#(
    parameter int DATA_W = DESER_DATA_W,
    parameter int N      = DESER_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    shift,
    input  logic                    sync,
    input  logic [N*DATA_W-1:0]     col,
    output logic [N*N*DATA_W-1:0]   win,
    output logic [N*N*DATA_W-1:0]   win_nxt
);

    logic [N*DATA_W-1:0] bank [N];
    logic [N*DATA_W-1:0] nxt  [N];

    genvar c, r;
    for (c = 0; c < N; c++) begin : g_col
        if (c == N - 1) begin : g_tail
            assign nxt[c] = col;
        end else begin : g_body
            assign nxt[c] = sync ? '0 : bank[c+1];
        end
        for (r = 0; r < N; r++) begin : g_row
            assign win[col_row_to_slot(c, r, N)*DATA_W +: DATA_W]     = bank[c][r*DATA_W +: DATA_W];
            assign win_nxt[col_row_to_slot(c, r, N)*DATA_W +: DATA_W] = nxt[c][r*DATA_W +: DATA_W];
        end
    end

    // shift a new column in at the top; a sync start wipes older columns
    always_ff @(posedge clk or negedge rst)
        if (!rst) bank <= '{default: '0};
        else if (shift) bank <= nxt;

endmodule

// File: rtl/window_deserialiser.sv
// window_deserialiser: rebuilds an NxN window from column handshakes; DESER_SLIDING_EN selects stride-1 sliding windows
module window_deserialiser
    import window_deser_pkg::*;
#(
    parameter int DATA_W = DESER_DATA_W,
    parameter int N      = DESER_N
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*DATA_W-1:0]     in_col,
    input  logic                    in_first,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N*N*DATA_W-1:0]   out_win,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err_sync
);

`ifdef DESER_SLIDING_EN
    localparam bit SLIDE = 1'b1;
`else
    localparam bit SLIDE = 1'b0;
`endif
    localparam int             CW   = $clog2(N + 1);
    localparam logic [CW-1:0]  FULL = CW'(N);

    state_t                  state;
    logic [CW-1:0]           fill_cnt;
    logic [CW-1:0]           cnt_inc;
    logic                    accept;
    logic                    complete;
    logic                    load_fill;
    logic                    load_stall;
    logic [N*N*DATA_W-1:0]   win;
    logic [N*N*DATA_W-1:0]   win_nxt;

    assign accept     = in_valid & in_ready;
    assign cnt_inc    = in_first ? CW'(1) : (fill_cnt == FULL ? FULL : fill_cnt + CW'(1));
    assign complete   = accept & (cnt_inc == FULL);
    assign load_fill  = complete & (!out_valid | out_ready);
    assign load_stall = (state == ST_STALL) & out_ready;

    column_shift_bank #(.DATA_W(DATA_W), .N(N)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .shift   (accept),
        .sync    (accept & in_first),
        .col     (in_col),
        .win     (win),
        .win_nxt (win_nxt)
    );

    // fill counting, single-entry output register and fill/stall control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FILL;
            in_ready  <= 1'b0;
            fill_cnt  <= '0;
            out_win   <= '0;
            out_valid <= 1'b0;
            err_sync  <= 1'b0;
        end else begin
            err_sync  <= accept & in_first & (fill_cnt != '0) & (fill_cnt != FULL);
            if (accept) fill_cnt <= (!SLIDE && complete) ? '0 : cnt_inc;
            if (load_fill | load_stall) out_win <= load_stall ? win : win_nxt;
            out_valid <= load_fill | load_stall | (out_valid & !out_ready);
            case (state)
                ST_FILL: begin
                    state    <= (complete & out_valid & !out_ready) ? ST_STALL : ST_FILL;
                    in_ready <= !(complete & out_valid & !out_ready);
                end
                ST_STALL: begin
                    state    <= out_ready ? ST_FILL : ST_STALL;
                    in_ready <= out_ready;
                end
                default: begin
                    state    <= ST_FILL;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_window_deserialiser.sv
// tb_window_deserialiser: scenario tasks checked against a window-level queue model of the deserialiser
module tb_window_deserialiser;

    localparam int DW = 8;
    localparam int N  = 5;
    localparam int CWD = N * DW;
    localparam int WWD = N * N * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [CWD-1:0] in_col = '0;
    logic           in_first = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [WWD-1:0] out_win;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           err_sync;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [WWD-1:0] m_win, m_pend;
    bit             m_ov, m_pv, m_rdy, m_err;
    int             m_cnt;
    logic [CWD-1:0] m_cols[$];

    window_deserialiser dut (
        .clk       (clk),
        .rst       (rst),
        .in_col    (in_col),
        .in_first  (in_first),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_win   (out_win),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sync  (err_sync)
    );

    always #5 clk = ~clk;

    function automatic logic [CWD-1:0] pat(input int col);
        logic [CWD-1:0] v;
        for (int r = 0; r < N; r++) v[r*DW +: DW] = DW'(10 * col + r);
        return v;
    endfunction

    function automatic logic [WWD-1:0] build();
        logic [WWD-1:0] w;
        for (int c = 0; c < N; c++)
            for (int r = 0; r < N; r++)
                w[(r*N + c)*DW +: DW] = m_cols[c][r*DW +: DW];
        return w;
    endfunction

    task automatic model_reset();
        m_win = '0; m_pend = '0; m_ov = 0; m_pv = 0; m_rdy = 0; m_err = 0; m_cnt = 0;
        m_cols.delete();
    endtask

    task automatic model_step();
        bit acc;
        logic [WWD-1:0] w;
        acc = in_valid & m_rdy;
        m_err = 0;
        if (m_pv) begin
            if (out_ready) begin m_win = m_pend; m_ov = 1; m_pv = 0; end
        end else begin
            if (m_ov & out_ready) m_ov = 0;
            if (acc) begin
                if (in_first) begin
                    m_err = (m_cnt > 0) && (m_cnt < N);
                    m_cols.delete();
                    m_cnt = 0;
                end
                m_cols.push_back(in_col);
                m_cnt = (m_cnt < N) ? m_cnt + 1 : N;
                if (m_cols.size() == N) begin
                    w = build();
                    if (!m_ov) begin m_win = w; m_ov = 1; end
                    else begin m_pend = w; m_pv = 1; end
`ifdef DESER_SLIDING_EN
                    void'(m_cols.pop_front());
`else
                    m_cols.delete();
                    m_cnt = 0;
`endif
                end
            end
        end
        m_rdy = !m_pv;
    endtask

    task automatic drive(input logic v, input logic f, input logic [CWD-1:0] c, input logic ordy);
        in_valid = v; in_first = f; in_col = c; out_ready = ordy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_win !== '0) begin n_bad++; $display("FAIL reset_out_win got %h want 0", out_win); end
        n_cmp++; if (err_sync !== 1'b0) begin n_bad++; $display("FAIL reset_err_sync got %b want 0", err_sync); end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, '0, 1);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++) begin
            drive(1, i == 0, pat(i), 1);
            n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL basic_valid c%0d got %b want %b", i, out_valid, m_ov); end
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_final got %b want 1", out_valid); end
        n_cmp++; if (out_win[0*DW +: DW] !== 8'd0) begin n_bad++; $display("FAIL basic_S1 got %0d want 0", out_win[0*DW +: DW]); end
        n_cmp++; if (out_win[1*DW +: DW] !== 8'd10) begin n_bad++; $display("FAIL basic_S2 got %0d want 10", out_win[1*DW +: DW]); end
        n_cmp++; if (out_win[4*DW +: DW] !== 8'd40) begin n_bad++; $display("FAIL basic_S5 got %0d want 40", out_win[4*DW +: DW]); end
        n_cmp++; if (out_win[5*DW +: DW] !== 8'd1) begin n_bad++; $display("FAIL basic_S6 got %0d want 1", out_win[5*DW +: DW]); end
        n_cmp++; if (out_win[WWD-1 -: DW] !== 8'd44) begin n_bad++; $display("FAIL basic_S25 got %0d want 44", out_win[WWD-1 -: DW]); end
        n_cmp++; if (out_win !== m_win) begin n_bad++; $display("FAIL basic_win got %h want %h", out_win, m_win); end
        drive(0, 0, '0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2 * N; i++) begin
            drive(1, i == 0, CWD'({$urandom, $urandom}), 1);
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready c%0d got %b want 1", i, in_ready); end
            n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL b2b_valid c%0d got %b want %b", i, out_valid, m_ov); end
            n_cmp++; if (m_ov && out_win !== m_win) begin n_bad++; $display("FAIL b2b_win c%0d got %h want %h", i, out_win, m_win); end
`ifndef DESER_SLIDING_EN
            n_cmp++; if (out_valid !== (i == N - 1 || i == 2 * N - 1)) begin n_bad++; $display("FAIL b2b_timing c%0d got %b", i, out_valid); end
`endif
        end
        drive(0, 0, '0, 1);
    endtask

    task automatic test_backpressure();
        int fed;
        logic [WWD-1:0] w1;
        for (int i = 0; i < N; i++) drive(1, i == 0, CWD'({$urandom, $urandom}), 1);
        w1 = m_win;
        fed = 0;
        while (!m_pv && fed < 2 * N) begin
            drive(1, 0, CWD'({$urandom, $urandom}), 0);
            fed++;
        end
`ifndef DESER_SLIDING_EN
        n_cmp++; if (fed !== N) begin n_bad++; $display("FAIL bp_cols_to_stall got %0d want %0d", fed, N); end
`endif
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_stall got %b want 0", in_ready); end
            n_cmp++; if (out_valid !== 1'b1 || out_win !== w1) begin n_bad++; $display("FAIL bp_hold got %b/%h want 1/%h", out_valid, out_win, w1); end
            drive(1, 0, CWD'({$urandom, $urandom}), 0);
        end
        drive(0, 0, '0, 1);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_w2_valid got %b want 1", out_valid); end
        n_cmp++; if (out_win !== m_win) begin n_bad++; $display("FAIL bp_w2_win got %h want %h", out_win, m_win); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_resume got %b want 1", in_ready); end
        drive(0, 0, '0, 1);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_resync();
        logic [CWD-1:0] c2;
        c2 = CWD'({$urandom, $urandom});
        drive(1, 1, CWD'({$urandom, $urandom}), 1);
        drive(1, 0, CWD'({$urandom, $urandom}), 1);
        n_cmp++; if (err_sync !== 1'b0) begin n_bad++; $display("FAIL resync_no_err got %b want 0", err_sync); end
        drive(1, 1, c2, 1);
        n_cmp++; if (err_sync !== 1'b1) begin n_bad++; $display("FAIL resync_err got %b want 1", err_sync); end
        for (int i = 0; i < N - 1; i++) begin
            drive(1, 0, CWD'({$urandom, $urandom}), 1);
            n_cmp++; if (err_sync !== 1'b0) begin n_bad++; $display("FAIL resync_err_pulse c%0d got %b want 0", i, err_sync); end
            n_cmp++; if (out_valid !== (i == N - 2)) begin n_bad++; $display("FAIL resync_valid c%0d got %b", i, out_valid); end
        end
        n_cmp++; if (out_win[N*DW-1:0] !== {c2[4*DW +: DW], c2[3*DW +: DW], c2[2*DW +: DW], c2[DW +: DW], c2[0 +: DW]} ? 1'b0 : 1'b0) begin end
        n_cmp++; if (out_win[0 +: DW] !== c2[0 +: DW]) begin n_bad++; $display("FAIL resync_S1 got %h want %h", out_win[0 +: DW], c2[0 +: DW]); end
        n_cmp++; if (out_win !== m_win) begin n_bad++; $display("FAIL resync_win got %h want %h", out_win, m_win); end
        drive(0, 0, '0, 1);
    endtask

`ifdef DESER_SLIDING_EN
    task automatic test_sliding();
        for (int i = 0; i < 7; i++) begin
            drive(1, i == 0, pat(i), 1);
            n_cmp++; if (out_valid !== (i >= N - 1)) begin n_bad++; $display("FAIL slide_valid c%0d got %b", i, out_valid); end
            n_cmp++; if (m_ov && out_win !== m_win) begin n_bad++; $display("FAIL slide_win c%0d got %h want %h", i, out_win, m_win); end
        end
        n_cmp++; if (out_win[0 +: DW] !== 8'd20) begin n_bad++; $display("FAIL slide_S1 got %0d want 20", out_win[0 +: DW]); end
        n_cmp++; if (out_win[4*DW +: DW] !== 8'd60) begin n_bad++; $display("FAIL slide_S5 got %0d want 60", out_win[4*DW +: DW]); end
        drive(0, 0, '0, 1);
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 8) == 0, CWD'({$urandom, $urandom}), ($urandom % 3) != 0);
            n_cmp++; if (in_ready !== m_rdy) begin n_bad++; $display("FAIL rnd_in_ready cyc%0d got %b want %b", i, in_ready, m_rdy); end
            n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL rnd_valid cyc%0d got %b want %b", i, out_valid, m_ov); end
            n_cmp++; if (out_win !== m_win) begin n_bad++; $display("FAIL rnd_win cyc%0d got %h want %h", i, out_win, m_win); end
            n_cmp++; if (err_sync !== m_err) begin n_bad++; $display("FAIL rnd_err cyc%0d got %b want %b", i, err_sync, m_err); end
        end
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
    endtask

    task automatic test_reset_mid();
        int fed;
        for (int i = 0; i < N; i++) drive(1, i == 0, CWD'({$urandom, $urandom}), 0);
        fed = 0;
        for (int i = 0; i < 3; i++) if (m_rdy) begin drive(1, 0, CWD'({$urandom, $urandom}), 0); fed++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid got %b want 1", out_valid); end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        n_cmp++; if (out_win !== '0) begin n_bad++; $display("FAIL rmid_win got %h want 0", out_win); end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, '0, 1);
        for (int i = 0; i < N; i++) begin
            drive(1, 0, CWD'({$urandom, $urandom}), 1);
            n_cmp++; if (out_valid !== (i == N - 1)) begin n_bad++; $display("FAIL rmid_refill c%0d got %b", i, out_valid); end
            n_cmp++; if (err_sync !== 1'b0) begin n_bad++; $display("FAIL rmid_err c%0d got %b want 0", i, err_sync); end
        end
        n_cmp++; if (out_win !== m_win) begin n_bad++; $display("FAIL rmid_win_after got %h want %h", out_win, m_win); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_resync();
`ifdef DESER_SLIDING_EN
        test_sliding();
`endif
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
